// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default baud divisor.
package uart_pkg;

    localparam int DEFAULT_CLOCKS_PER_BAUD = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VALUE.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rxuart_core.sv
// 8N1 UART receiver: mid-bit sampling driven by a down-counting baud timer.
module rxuart_core
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_data,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_BAUD = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BAUD = CNT_W'(CLOCKS_PER_BAUD - 1);

    uart_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       data_next;
    logic             stb_next, err_next;
    logic             rx_s;
    logic             expire;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (i_clk),
        .reset (i_reset),
        .d     (i_uart_rx),
        .q     (rx_s)
    );

    assign expire    = (cnt == '0);
    assign o_rx_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_rx_data   <= '0;
            o_rx_stb    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shreg       <= shreg_next;
            o_rx_data   <= data_next;
            o_rx_stb    <= stb_next;
            o_frame_err <= err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        data_next  = o_rx_data;
        stb_next   = 1'b0;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_next   = HALF_BAUD;
                    state_next = START;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (rx_s) begin
                    state_next = IDLE;  // start bit was a glitch
                end else begin
                    cnt_next   = FULL_BAUD;
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    shreg_next[idx] = rx_s;
                    cnt_next        = FULL_BAUD;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (rx_s) begin
                    data_next  = shreg;
                    stb_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    err_next   = 1'b1;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // a break holds the line low; only one error is reported for it
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/rxuart_core.md
RXUART_CORE -- requirements
Module: rxuart_core

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 16, meaning i_clk cycles per bit period (legal range 4..65535).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port i_uart_rx, input, 1, asynchronous serial line; idle high.
REQ-005 SHALL have port o_rx_stb, output, 1, one-cycle pulse: o_rx_data holds a valid byte.
REQ-006 SHALL have port o_rx_data, output, 8, last correctly received byte.
REQ-007 SHALL have port o_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port o_rx_busy, output, 1, high whenever state is not IDLE.

Function
REQ-009 SHALL pass i_uart_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-010 Frame format SHALL be 8N1: start bit low, 8 data bits LSB first, one stop bit high.
REQ-011 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: on rx_s==0, load baud counter with CLOCKS_PER_BAUD/2 - 1 and enter START.
REQ-013 START: when the counter reaches 0, sample rx_s; if 1 (glitch), return to IDLE with no pulse; if 0, reload counter to CLOCKS_PER_BAUD-1, clear bit index, enter DATA.
REQ-014 DATA: at each counter expiry, shift rx_s into bit [index] of a shift register, reload counter; after index 7, enter STOP.
REQ-015 STOP: at counter expiry, if rx_s==1, copy shift register to o_rx_data, pulse o_rx_stb the next cycle, enter IDLE.
REQ-016 STOP: at counter expiry, if rx_s==0, pulse o_frame_err the next cycle, leave o_rx_data unchanged, enter WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rx_s==1, then enter IDLE; a held-low line (break) SHALL produce exactly one o_frame_err.
REQ-018 o_rx_stb and o_frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 Latency SHALL be 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD + 1 cycles from the i_uart_rx falling edge to o_rx_stb (155 cycles at 16).
REQ-020 A new start bit SHALL be accepted in the first IDLE cycle after the STOP sample, so back-to-back frames with a 1-bit stop SHALL all be received.
REQ-021 Baud counter width SHALL be $clog2(CLOCKS_PER_BAUD); integer division SHALL truncate for odd CLOCKS_PER_BAUD.

Reset
REQ-022 While i_reset is high: state=IDLE, o_rx_stb=0, o_frame_err=0, o_rx_busy=0, o_rx_data=8'h00, synchronizer flops=1, counter and index=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; the next frame SHALL need a fresh falling edge after reset release.

Structure
REQ-024 The state encoding and the default CLOCKS_PER_BAUD constant SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (1-bit, reset value parameterized, here 1).

Verification (CLOCKS_PER_BAUD=16)
REQ-026 Drive byte 8'hA5 as 8N1 -> o_rx_stb pulses once, 155 cycles after the start edge, o_rx_data=8'hA5, o_frame_err stays 0.
REQ-027 Drive 8'h00, 8'hFF, 8'h55 back-to-back, 1 stop bit each -> three o_rx_stb pulses with those values, in order.
REQ-028 Pulse i_uart_rx low for 4 cycles only -> no pulses; o_rx_busy returns to 0 within 12 cycles.
REQ-029 Drive 8'h3C with the stop bit low, then hold the line low for 40 bit times -> exactly one o_frame_err, o_rx_data keeps its prior value, o_rx_busy stays high until the line returns high.
REQ-030 Assert i_reset during data bit 4 of a frame -> no pulse, all outputs at reset values; a following 8'h81 frame is received correctly.
REQ-031 Drive 8'hC3 at a bit period of 17 and of 15 cycles -> o_rx_data=8'hC3 in both cases.
